// File: rtl/arbitro_pkg.sv
// rtl/arbitro_pkg.sv - shared defaults and FSM state type for the VC weighted round-robin arbiter
package arbitro_pkg;

  localparam int DATA_W_DEF   = 6;
  localparam int DEST_BIT_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TURN0 = 2'd1,
    ST_TURN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arbitro_route_reg.sv
// rtl/arbitro_route_reg.sv - registered demux steering a popped word to D0 or D1 by its destination bit
module arbitro_route_reg
  import arbitro_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEST_BIT = DEST_BIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] d0_data,
  output logic              d0_push,
  output logic [DATA_W-1:0] d1_data,
  output logic              d1_push
);

  logic [DATA_W-1:0] d0_data_q, d0_data_d;
  logic [DATA_W-1:0] d1_data_q, d1_data_d;
  logic              d0_push_q, d0_push_d;
  logic              d1_push_q, d1_push_d;

  // Data registers hold between pushes; only the selected side is overwritten.
  always_comb begin
    d0_data_d = d0_data_q;
    d1_data_d = d1_data_q;
    d0_push_d = 1'b0;
    d1_push_d = 1'b0;
    if (in_valid) begin
      if (in_data[DEST_BIT]) begin
        d1_data_d = in_data;
        d1_push_d = 1'b1;
      end else begin
        d0_data_d = in_data;
        d0_push_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d0_data_q <= '0;
      d1_data_q <= '0;
      d0_push_q <= 1'b0;
      d1_push_q <= 1'b0;
    end else begin
      d0_data_q <= d0_data_d;
      d1_data_q <= d1_data_d;
      d0_push_q <= d0_push_d;
      d1_push_q <= d1_push_d;
    end
  end

  assign d0_data = d0_data_q;
  assign d0_push = d0_push_q;
  assign d1_data = d1_data_q;
  assign d1_push = d1_push_q;

endmodule

// File: rtl/arbitro_wrr_vc.sv
// rtl/arbitro_wrr_vc.sv - weighted round-robin scheduler from VC0/VC1 into destination FIFOs D0/D1
module arbitro_wrr_vc
  import arbitro_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEST_BIT = DEST_BIT_DEF,
  parameter int WEIGHT0  = 2,
  parameter int WEIGHT1  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] vc0_data,
  input  logic              vc0_empty,
  input  logic [DATA_W-1:0] vc1_data,
  input  logic              vc1_empty,
  input  logic              d0_almost_full,
  input  logic              d1_almost_full,
  output logic              vc0_pop,
  output logic              vc1_pop,
  output logic [DATA_W-1:0] d0_data,
  output logic              d0_push,
  output logic [DATA_W-1:0] d1_data,
  output logic              d1_push,
  output logic              grant_vc
);

  localparam int WMAX  = (WEIGHT0 > WEIGHT1) ? WEIGHT0 : WEIGHT1;
  localparam int CNT_W = $clog2(WMAX + 1);
  localparam logic [CNT_W-1:0] W0_C  = CNT_W'(WEIGHT0);
  localparam logic [CNT_W-1:0] W1_C  = CNT_W'(WEIGHT1);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic              grant_vc_q, grant_vc_d;

  logic              elig0, elig1;
  logic              own_vc, own_elig, oth_elig;
  logic [CNT_W-1:0]  own_w;
  logic              gnt_valid, gnt_vc;
  logic [DATA_W-1:0] gnt_data;

  // A VC is only eligible when its head word's destination has room, so a
  // blocked head never stalls the other VC.
  assign elig0 = !vc0_empty && !(vc0_data[DEST_BIT] ? d1_almost_full : d0_almost_full);
  assign elig1 = !vc1_empty && !(vc1_data[DEST_BIT] ? d1_almost_full : d0_almost_full);

  assign own_vc   = (state_q == ST_TURN1);
  assign own_elig = own_vc ? elig1 : elig0;
  assign oth_elig = own_vc ? elig0 : elig1;
  assign own_w    = own_vc ? W1_C : W0_C;

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    gnt_valid   = 1'b0;
    gnt_vc      = 1'b0;
    if (state_q == ST_TURN0 || state_q == ST_TURN1) begin
      if (own_elig && (burst_cnt_q < own_w)) begin
        gnt_valid   = 1'b1;
        gnt_vc      = own_vc;
        burst_cnt_d = burst_cnt_q + ONE_C;
      end else if (oth_elig) begin
        gnt_valid   = 1'b1;
        gnt_vc      = !own_vc;
        state_d     = own_vc ? ST_TURN0 : ST_TURN1;
        burst_cnt_d = ONE_C;
      end else if (own_elig) begin
        // Burst spent but the other VC has nothing to send: keep going, saturated.
        gnt_valid   = 1'b1;
        gnt_vc      = own_vc;
        burst_cnt_d = own_w;
      end else begin
        state_d     = ST_IDLE;
        burst_cnt_d = '0;
      end
    end else begin
      state_d     = ST_IDLE;
      burst_cnt_d = '0;
      if (elig0) begin
        gnt_valid   = 1'b1;
        gnt_vc      = 1'b0;
        state_d     = ST_TURN0;
        burst_cnt_d = ONE_C;
      end else if (elig1) begin
        gnt_valid   = 1'b1;
        gnt_vc      = 1'b1;
        state_d     = ST_TURN1;
        burst_cnt_d = ONE_C;
      end
    end
  end

  assign grant_vc_d = gnt_valid ? gnt_vc : grant_vc_q;
  assign gnt_data   = gnt_vc ? vc1_data : vc0_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      burst_cnt_q <= '0;
      grant_vc_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      grant_vc_q  <= grant_vc_d;
    end
  end

  assign vc0_pop  = gnt_valid && !gnt_vc && !reset;
  assign vc1_pop  = gnt_valid &&  gnt_vc && !reset;
  assign grant_vc = grant_vc_q;

  arbitro_route_reg #(
    .DATA_W   (DATA_W),
    .DEST_BIT (DEST_BIT)
  ) u_route (
    .clk      (clk),
    .reset    (reset),
    .in_data  (gnt_data),
    .in_valid (gnt_valid),
    .d0_data  (d0_data),
    .d0_push  (d0_push),
    .d1_data  (d1_data),
    .d1_push  (d1_push)
  );

endmodule

// File: tb/tb_arbitro_wrr_vc.sv
// tb/tb_arbitro_wrr_vc.sv - randomized and directed checks of arbitro_wrr_vc against a queue-based model
module tb_arbitro_wrr_vc;

  localparam int DW = 6;
  localparam int DB = 4;
  localparam int W0 = 2;
  localparam int W1 = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] vc0_data, vc1_data;
  logic          vc0_empty, vc1_empty;
  logic          d0_almost_full, d1_almost_full;
  logic          vc0_pop, vc1_pop;
  logic [DW-1:0] d0_data, d1_data;
  logic          d0_push, d1_push;
  logic          grant_vc;

  always #5 clk = ~clk;

  arbitro_wrr_vc #(
    .DATA_W   (DW),
    .DEST_BIT (DB),
    .WEIGHT0  (W0),
    .WEIGHT1  (W1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .vc0_data       (vc0_data),
    .vc0_empty      (vc0_empty),
    .vc1_data       (vc1_data),
    .vc1_empty      (vc1_empty),
    .d0_almost_full (d0_almost_full),
    .d1_almost_full (d1_almost_full),
    .vc0_pop        (vc0_pop),
    .vc1_pop        (vc1_pop),
    .d0_data        (d0_data),
    .d0_push        (d0_push),
    .d1_data        (d1_data),
    .d1_push        (d1_push),
    .grant_vc       (grant_vc)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: FIFO contents as queues, the arbiter as "who owns the turn and for how long".
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic          af0, af1;
  int            turn, streak;
  logic [DW-1:0] e_d0, e_d1;
  logic          e_p0, e_p1, e_gvc;
  bit            rand_mode = 0;
  int            pop_log[$];

  function automatic bit elig(input int vc);
    logic [DW-1:0] w;
    if (vc == 0) begin
      if (q0.size() == 0) return 0;
      w = q0[0];
    end else begin
      if (q1.size() == 0) return 0;
      w = q1[0];
    end
    return w[DB] ? !af1 : !af0;
  endfunction

  function automatic int model_pick();
    int o, w;
    if (reset) return -1;
    if (turn < 0) return elig(0) ? 0 : (elig(1) ? 1 : -1);
    o = 1 - turn;
    w = (turn == 0) ? W0 : W1;
    if (elig(turn) && streak < w) return turn;
    if (elig(o)) return o;
    if (elig(turn)) return turn;
    return -1;
  endfunction

  task automatic clear_model();
    turn = -1; streak = 0;
    e_d0 = '0; e_d1 = '0; e_p0 = 0; e_p1 = 0; e_gvc = 0;
  endtask

  task automatic drive();
    if (rand_mode) begin
      if ($urandom_range(0, 3) != 0 && q0.size() < 8) q0.push_back(DW'($urandom));
      if ($urandom_range(0, 2) == 0 && q1.size() < 8) q1.push_back(DW'($urandom));
      af0 = ($urandom_range(0, 4) == 0);
      af1 = ($urandom_range(0, 4) == 0);
    end
    vc0_empty      = (q0.size() == 0);
    vc1_empty      = (q1.size() == 0);
    vc0_data       = vc0_empty ? DW'($urandom) : q0[0];
    vc1_data       = vc1_empty ? DW'($urandom) : q1[0];
    d0_almost_full = af0;
    d1_almost_full = af1;
  endtask

  task automatic cycle(input bit rst_mid);
    int            g, wt;
    logic [DW-1:0] w;
    drive();
    @(negedge clk);
    g = model_pick();
    chk("vc0_pop",   vc0_pop,  g == 0);
    chk("vc1_pop",   vc1_pop,  g == 1);
    chk("d0_push",   d0_push,  e_p0);
    chk("d1_push",   d1_push,  e_p1);
    chk("d0_data",   d0_data,  e_d0);
    chk("d1_data",   d1_data,  e_d1);
    chk("grant_vc",  grant_vc, e_gvc);
    chk("burst_cnt", dut.burst_cnt_q, streak);
    if (vc0_pop) pop_log.push_back(0);
    if (vc1_pop) pop_log.push_back(1);
    if (rst_mid) begin
      #1 reset = 1'b1;
      clear_model();
      g = -1;
      #1;
      chk("pop_in_rst",  {vc0_pop, vc1_pop}, 0);
      chk("push_in_rst", {d0_push, d1_push}, 0);
    end
    @(posedge clk);
    if (reset) begin
      clear_model();
    end else if (g < 0) begin
      e_p0 = 0; e_p1 = 0; turn = -1; streak = 0;
    end else begin
      w  = (g == 0) ? q0.pop_front() : q1.pop_front();
      wt = (g == 0) ? W0 : W1;
      if (w[DB]) begin e_d1 = w; e_p1 = 1; e_p0 = 0; end
      else       begin e_d0 = w; e_p0 = 1; e_p1 = 0; end
      e_gvc = g[0];
      if (g == turn) streak = (streak < wt) ? streak + 1 : wt;
      else begin turn = g; streak = 1; end
    end
    #1;
  endtask

  initial begin
    reset = 1'b1;
    af0 = 0; af1 = 0;
    clear_model();

    // Reset held with both VCs non-empty: nothing moves.
    repeat (2) q0.push_back(6'b100101);
    repeat (2) q1.push_back(6'b100101);
    repeat (2) cycle(0);
    q0.delete(); q1.delete();
    reset = 1'b0;
    repeat (2) cycle(0);

    // Weighted sharing with both VCs backlogged to D0.
    pop_log.delete();
    repeat (6) q0.push_back(6'b100101);
    repeat (6) q1.push_back(6'b100101);
    repeat (14) cycle(0);
    chk("wrr_len", pop_log.size() >= 9, 1);
    if (pop_log.size() >= 9)
      for (int i = 0; i < 9; i++) chk("wrr_seq", pop_log[i], (i % 3) == 2);

    // Routing by destination bit.
    q0.push_back(6'b110100);
    repeat (2) cycle(0);
    chk("route_d1", d1_data, 6'b110100);
    q1.push_back(6'b101100);
    repeat (2) cycle(0);
    chk("route_d0", d0_data, 6'b101100);

    // D1 almost full: VC0 head blocked, VC1 to D0 still flows.
    af1 = 1;
    q0.push_back(6'b110110);
    repeat (3) q1.push_back(6'b100101);
    repeat (3) cycle(0);
    chk("hol_vc0_held", q0.size(), 1);
    af1 = 0;
    repeat (3) cycle(0);
    chk("hol_vc0_done", q0.size(), 0);

    // Burst saturation with VC1 idle, then VC1 arrives.
    repeat (5) q0.push_back(6'b000011);
    repeat (5) cycle(0);
    chk("sat_cnt", dut.burst_cnt_q, 2);
    q1.push_back(6'b001001);
    pop_log.delete();
    cycle(0);
    chk("sat_vc1_next", (pop_log.size() == 1) ? pop_log[0] : 9, 1);
    repeat (2) cycle(0);

    // Reset right after a pop: that push must never appear.
    repeat (3) q0.push_back(6'b010101);
    repeat (3) q1.push_back(6'b000111);
    cycle(0);
    cycle(1);
    cycle(0);
    reset = 1'b0;
    pop_log.delete();
    repeat (8) cycle(0);
    chk("rst_first_vc0", (pop_log.size() > 0) ? pop_log[0] : 9, 0);

    // Random traffic and back-pressure with occasional resets.
    rand_mode = 1;
    for (int i = 0; i < 400; i++) begin
      if (reset) reset = 1'b0;
      cycle($urandom_range(0, 60) == 0);
    end
    rand_mode = 0;
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
